// File: rtl/eu_iqueue.sv
// rtl/eu_iqueue.sv - per-exec-unit instruction queue feeding the ALPU operand cache
// Oldest entry drives curr_instr; the second-oldest is exposed as a prefetch hint.
module eu_iqueue #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 64,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] in_instr,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [ENTRY_W-1:0] curr_instr,
   output logic               curr_valid,
   input  logic               curr_ready,
   output logic [ENTRY_W-1:0] next_instr,
   output logic               next_valid,
   output logic [PTR_W:0]     count,
   output logic               full,
   output logic               empty
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [PTR_W-1:0]   rd_ptr_nxt;
   logic               push, pop;

   // Every output derives from registered state only; no in_instr bypass.
   assign full       = (count_q == (PTR_W+1)'(DEPTH));
   assign empty      = (count_q == '0);
   assign in_ready   = ~full;
   assign curr_valid = ~empty;
   assign next_valid = (count_q >= (PTR_W+1)'(2));
   assign count      = count_q;
   assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
   assign curr_instr = mem_q[rd_ptr_q];
   assign next_instr = mem_q[rd_ptr_nxt];

   assign push = in_valid & in_ready;
   assign pop  = curr_valid & curr_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_nxt;
         if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
         else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push && !flush) mem_q[wr_ptr_q] <= in_instr;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow:  assert property (@(posedge clk) disable iff (!reset_n) !(push && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));
`endif

endmodule
